// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry decode/execute pipeline register.
// Holds one decoded instruction and drives the ALU operands and opcode
// directly from it. M-extension ops occupy the stage for a fixed
// number of cycles before they are presented. Source operands are
// forwarded from EX/MEM and MEM/WB, and stored operands are refreshed
// while the instruction waits, so a producer retiring during a stall is
// not lost.
`timescale 1ns/1ps
module id_ex_stage #(
  parameter int MDIV_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // decode-side handshake and instruction fields
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_pc,
  input  logic [31:0] i_in_rs1_data,
  input  logic [31:0] i_in_rs2_data,
  input  logic [31:0] i_in_imm,
  input  logic [4:0]  i_in_rs1_addr,
  input  logic [4:0]  i_in_rs2_addr,
  input  logic [4:0]  i_in_rd_addr,
  input  logic [4:0]  i_in_alu_op,
  input  logic        i_in_use_imm,
  input  logic        i_in_use_pc,
  input  logic        i_in_reg_write,
  input  logic        i_flush,
  // forwarding sources
  input  logic [4:0]  i_exmem_rd_addr,
  input  logic [4:0]  i_memwb_rd_addr,
  input  logic        i_exmem_reg_write,
  input  logic        i_memwb_reg_write,
  input  logic [31:0] i_exmem_result,
  input  logic [31:0] i_memwb_result,
  // execute-side handshake and operand drive
  input  logic        i_out_ready,
  output logic        o_out_valid,
  output logic [31:0] o_data1,
  output logic [31:0] o_data2,
  output logic [4:0]  o_opcode,
  output logic [31:0] o_out_pc,
  output logic [31:0] o_out_rs2_data,
  output logic [4:0]  o_out_rd_addr,
  output logic        o_out_reg_write
);

  localparam int CW = $clog2(MDIV_CYCLES + 1);
  localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(MDIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  state_t          w_load_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_load_cnt;

  logic [31:0] r_pc;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd_addr;
  logic [4:0]  r_alu_op;
  logic        r_use_imm;
  logic        r_use_pc;
  logic        r_reg_write;

  logic        w_capture;
  logic        w_active;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;

  // Newest producer wins: EX/MEM over MEM/WB; register x0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [31:0] stored,
    input logic        ex_we,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_res,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_res
  );
    logic [31:0] v;
    if (rs == 5'd0) begin
      v = stored;
    end else if (ex_we && (ex_rd == rs)) begin
      v = ex_res;
    end else if (wb_we && (wb_rd == rs)) begin
      v = wb_res;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Handshake, capture qualification and forwarded operand values.
  always_comb begin
    w_active   = (r_state == ST_WAIT) || (r_state == ST_FULL);
    o_in_ready = i_flush || (r_state == ST_EMPTY) ||
                 ((r_state == ST_FULL) && i_out_ready);
    w_capture  = i_in_valid && o_in_ready && !i_flush;
    w_fwd_rs1  = fwd_sel(r_rs1_addr, r_rs1_data,
                         i_exmem_reg_write, i_exmem_rd_addr, i_exmem_result,
                         i_memwb_reg_write, i_memwb_rd_addr, i_memwb_result);
    w_fwd_rs2  = fwd_sel(r_rs2_addr, r_rs2_data,
                         i_exmem_reg_write, i_exmem_rd_addr, i_exmem_result,
                         i_memwb_reg_write, i_memwb_rd_addr, i_memwb_result);
    if (i_in_alu_op[4]) begin
      w_load_state = ST_WAIT;
      w_load_cnt   = LP_CNT_ONE;
    end else begin
      w_load_state = ST_FULL;
      w_load_cnt   = '0;
    end
  end

  // Next-state and occupancy counter; flush overrides capture and completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_capture) begin
            w_state_nxt = w_load_state;
            w_cnt_nxt   = w_load_cnt;
          end else begin
            w_state_nxt = ST_EMPTY;
            w_cnt_nxt   = '0;
          end
        end
        ST_WAIT: begin
          if (r_cnt == LP_CNT_LAST) begin
            w_state_nxt = ST_FULL;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = r_cnt + LP_CNT_ONE;
          end
        end
        ST_FULL: begin
          if (i_out_ready && w_capture) begin
            w_state_nxt = w_load_state;
            w_cnt_nxt   = w_load_cnt;
          end else if (i_out_ready) begin
            w_state_nxt = ST_EMPTY;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_FULL;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Instruction fields: load on capture, refresh operands while held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc        <= 32'd0;
      r_rs1_data  <= 32'd0;
      r_rs2_data  <= 32'd0;
      r_imm       <= 32'd0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_alu_op    <= 5'd0;
      r_use_imm   <= 1'b0;
      r_use_pc    <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (i_flush) begin
      r_reg_write <= 1'b0;
    end else if (w_capture) begin
      r_pc        <= i_in_pc;
      r_rs1_data  <= i_in_rs1_data;
      r_rs2_data  <= i_in_rs2_data;
      r_imm       <= i_in_imm;
      r_rs1_addr  <= i_in_rs1_addr;
      r_rs2_addr  <= i_in_rs2_addr;
      r_rd_addr   <= i_in_rd_addr;
      r_alu_op    <= i_in_alu_op;
      r_use_imm   <= i_in_use_imm;
      r_use_pc    <= i_in_use_pc;
      r_reg_write <= i_in_reg_write;
    end else if (w_active) begin
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
      if ((r_state == ST_FULL) && i_out_ready) begin
        r_reg_write <= 1'b0;
      end else begin
        r_reg_write <= r_reg_write;
      end
    end else begin
      r_reg_write <= r_reg_write;
    end
  end

  // Output drive: operands and opcode only while an instruction is held.
  always_comb begin
    o_out_valid     = (r_state == ST_FULL);
    o_out_pc        = r_pc;
    o_out_rs2_data  = w_fwd_rs2;
    o_out_rd_addr   = r_rd_addr;
    o_out_reg_write = r_reg_write;
    if (w_active) begin
      o_data1  = r_use_pc  ? r_pc  : w_fwd_rs1;
      o_data2  = r_use_imm ? r_imm : w_fwd_rs2;
      o_opcode = r_alu_op;
    end else begin
      o_data1  = 32'd0;
      o_data2  = 32'd0;
      o_opcode = 5'd0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage.
// Stimulus pushes each accepted instruction into a queue and applies the
// "latest producer wins" rule to the held entry; a monitor pops and
// compares whenever the DUT transfers an output.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int MDIV = 3;

  typedef struct packed {
    logic        rst;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [4:0]  op;
    logic        use_imm;
    logic        use_pc;
    logic        we;
    logic        flush;
    logic [4:0]  ex_rd;
    logic [4:0]  wb_rd;
    logic        ex_we;
    logic        wb_we;
    logic [31:0] ex_res;
    logic [31:0] wb_res;
    logic        out_ready;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
    logic [4:0]  op;
    logic        use_pc;
    logic        use_imm;
    logic        we;
  } exp_t;

  logic  clk = 1'b0;
  stim_t d;
  stim_t n;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  logic  m_busy = 1'b0;
  int    m_left = 0;
  logic  mon_popped = 1'b0;

  logic        o_in_ready, o_out_valid, o_out_reg_write;
  logic [31:0] o_data1, o_data2, o_out_pc, o_out_rs2_data;
  logic [4:0]  o_opcode, o_out_rd_addr;

  id_ex_stage #(.MDIV_CYCLES(MDIV)) dut (
    .i_clk(clk), .i_rst(d.rst),
    .i_in_valid(d.in_valid), .o_in_ready(o_in_ready),
    .i_in_pc(d.pc), .i_in_rs1_data(d.rs1d), .i_in_rs2_data(d.rs2d), .i_in_imm(d.imm),
    .i_in_rs1_addr(d.rs1a), .i_in_rs2_addr(d.rs2a), .i_in_rd_addr(d.rda),
    .i_in_alu_op(d.op), .i_in_use_imm(d.use_imm), .i_in_use_pc(d.use_pc),
    .i_in_reg_write(d.we), .i_flush(d.flush),
    .i_exmem_rd_addr(d.ex_rd), .i_memwb_rd_addr(d.wb_rd),
    .i_exmem_reg_write(d.ex_we), .i_memwb_reg_write(d.wb_we),
    .i_exmem_result(d.ex_res), .i_memwb_result(d.wb_res),
    .i_out_ready(d.out_ready), .o_out_valid(o_out_valid),
    .o_data1(o_data1), .o_data2(o_data2), .o_opcode(o_opcode),
    .o_out_pc(o_out_pc), .o_out_rs2_data(o_out_rs2_data),
    .o_out_rd_addr(o_out_rd_addr), .o_out_reg_write(o_out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: apply the next stimulus at negedge and fold forwarding
  // writes seen by the held instruction into its expected operands.
  task automatic cycle();
    @(negedge clk);
    d = n;
    if (!d.rst && !d.flush && m_busy && (q.size() > 0)) begin
      if (d.wb_we && (d.wb_rd == q[0].rs1a) && (q[0].rs1a != 5'd0)) q[0].rs1v = d.wb_res;
      if (d.ex_we && (d.ex_rd == q[0].rs1a) && (q[0].rs1a != 5'd0)) q[0].rs1v = d.ex_res;
      if (d.wb_we && (d.wb_rd == q[0].rs2a) && (q[0].rs2a != 5'd0)) q[0].rs2v = d.wb_res;
      if (d.ex_we && (d.ex_rd == q[0].rs2a) && (q[0].rs2a != 5'd0)) q[0].rs2v = d.ex_res;
    end
    #3;
  endtask

  function automatic stim_t idle(input logic rdy);
    stim_t s;
    s = '0;
    s.out_ready = rdy;
    return s;
  endfunction

  function automatic stim_t instr(input logic [4:0] op, input logic [4:0] rs1a,
                                  input logic [31:0] rs1d, input logic [4:0] rs2a,
                                  input logic [31:0] rs2d, input logic rdy);
    stim_t s;
    s = '0;
    s.in_valid = 1'b1;
    s.op = op; s.rs1a = rs1a; s.rs1d = rs1d; s.rs2a = rs2a; s.rs2d = rs2d;
    s.pc = 32'h0000_1000; s.imm = 32'h0000_0040; s.rda = 5'd4; s.we = 1'b1;
    s.out_ready = rdy;
    return s;
  endfunction

  // Reference model: occupancy with a countdown to presentation.
  initial forever begin
    logic xfer, cap;
    exp_t e, tmp;
    @(posedge clk);
    if (d.rst || d.flush) begin
      m_busy = 1'b0;
      m_left = 0;
      q.delete();
    end else begin
      xfer = m_busy && (m_left == 0) && d.out_ready;
      cap  = d.in_valid && (!m_busy || xfer);
      if (xfer) begin
        m_busy = 1'b0;
        if (!mon_popped && (q.size() > 0)) tmp = q.pop_front();
      end else if (m_busy && (m_left > 0)) begin
        m_left--;
      end
      if (cap) begin
        e.pc = d.pc; e.rs1v = d.rs1d; e.rs2v = d.rs2d; e.imm = d.imm;
        e.rs1a = d.rs1a; e.rs2a = d.rs2a; e.rd = d.rda; e.op = d.op;
        e.use_pc = d.use_pc; e.use_imm = d.use_imm; e.we = d.we;
        q.push_back(e);
        m_busy = 1'b1;
        m_left = d.op[4] ? (MDIV - 1) : 0;
      end
    end
    mon_popped = 1'b0;
  end

  // Monitor: handshake checks every cycle, scoreboard compare on transfer.
  initial forever begin
    logic ev;
    exp_t e;
    @(negedge clk);
    #2;
    if (!d.rst) begin
      ev = m_busy && (m_left == 0);
      chk("out_valid", 32'(o_out_valid), 32'(ev));
      chk("in_ready", 32'(o_in_ready), 32'(d.flush | !m_busy | (ev & d.out_ready)));
      if (!m_busy) begin
        chk("empty_opcode", 32'(o_opcode), 32'd0);
        chk("empty_data1", o_data1, 32'd0);
        chk("empty_data2", o_data2, 32'd0);
      end
      if (o_out_valid && d.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=valid expected=none t=%0t", $time);
        end else begin
          e = q.pop_front();
          mon_popped = 1'b1;
          chk("sb_data1", o_data1, e.use_pc ? e.pc : e.rs1v);
          chk("sb_data2", o_data2, e.use_imm ? e.imm : e.rs2v);
          chk("sb_opcode", 32'(o_opcode), 32'(e.op));
          chk("sb_pc", o_out_pc, e.pc);
          chk("sb_rs2_data", o_out_rs2_data, e.rs2v);
          chk("sb_rd", 32'(o_out_rd_addr), 32'(e.rd));
          chk("sb_reg_write", 32'(o_out_reg_write), 32'(e.we));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d = idle(1'b0);
    d.rst = 1'b1;
    n = d;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_reg_write", 32'(o_out_reg_write), 32'd0);
    chk("rst_opcode", 32'(o_opcode), 32'd0);
    chk("rst_data1", o_data1, 32'd0);
    chk("rst_data2", o_data2, 32'd0);
    chk("rst_pc", o_out_pc, 32'd0);
    chk("rst_rs2", o_out_rs2_data, 32'd0);
    chk("rst_rd", 32'(o_out_rd_addr), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);

    // ADD back-to-back, first capture on the first edge after release
    n = instr(5'b00000, 5'd1, 32'd5, 5'd2, 32'd7, 1'b1);
    cycle();
    chk("add_in_ready", 32'(o_in_ready), 32'd1);
    n = instr(5'b00000, 5'd1, 32'd9, 5'd2, 32'd1, 1'b1);
    cycle();
    chk("add_valid", 32'(o_out_valid), 32'd1);
    chk("add_data1", o_data1, 32'd5);
    chk("add_data2", o_data2, 32'd7);
    chk("add_opcode", 32'(o_opcode), 32'd0);
    chk("add_b2b_ready", 32'(o_in_ready), 32'd1);
    n = idle(1'b1);
    cycle();

    // M op occupancy
    n = instr(5'b10000, 5'd1, 32'd3, 5'd2, 32'd4, 1'b1);
    cycle();
    n = idle(1'b1);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("mop_valid", 32'(o_out_valid), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) chk("mop_in_ready", 32'(o_in_ready), 32'd0);
    end

    // forwarding priority and x0
    n = instr(5'b00000, 5'd3, 32'h99, 5'd0, 32'd0, 1'b0);
    cycle();
    n = idle(1'b0);
    n.ex_we = 1'b1; n.ex_rd = 5'd3; n.ex_res = 32'h11;
    n.wb_we = 1'b1; n.wb_rd = 5'd3; n.wb_res = 32'h22;
    cycle();
    chk("fwd_exmem_first", o_data1, 32'h11);
    n = idle(1'b1);
    cycle();
    n = instr(5'b00000, 5'd0, 32'h55, 5'd0, 32'd0, 1'b0);
    cycle();
    n = idle(1'b0);
    n.ex_we = 1'b1; n.ex_rd = 5'd0; n.ex_res = 32'hDEAD;
    n.wb_we = 1'b1; n.wb_rd = 5'd0; n.wb_res = 32'hBEEF;
    cycle();
    chk("fwd_x0", o_data1, 32'h55);
    n = idle(1'b1);
    cycle();

    // stall with a MEM/WB producer passing in stall cycle 2 only
    n = instr(5'b00000, 5'd1, 32'd1, 5'd6, 32'h10, 1'b0);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      n = idle(1'b0);
      if (k == 2) begin
        n.wb_we = 1'b1; n.wb_rd = 5'd6; n.wb_res = 32'hAB;
      end
      cycle();
      chk("stall_data2", o_data2, (k >= 2) ? 32'hAB : 32'h10);
    end
    n = idle(1'b1);
    cycle();
    chk("stall_release_data2", o_data2, 32'hAB);

    // flush in WAIT with an offered instruction
    n = instr(5'b10001, 5'd1, 32'd2, 5'd2, 32'd3, 1'b0);
    cycle();
    n = instr(5'b00000, 5'd1, 32'h77, 5'd2, 32'h88, 1'b0);
    n.flush = 1'b1;
    cycle();
    n = idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("flush_valid", 32'(o_out_valid), 32'd0);
      chk("flush_reg_write", 32'(o_out_reg_write), 32'd0);
      chk("flush_opcode", 32'(o_opcode), 32'd0);
    end

    // asynchronous reset mid-FULL
    n = instr(5'b00011, 5'd1, 32'd2, 5'd2, 32'd3, 1'b0);
    cycle();
    n = idle(1'b0);
    cycle();
    chk("pre_rst_valid", 32'(o_out_valid), 32'd1);
    d.rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_out_valid), 32'd0);
    chk("async_rst_reg_write", 32'(o_out_reg_write), 32'd0);
    chk("async_rst_in_ready", 32'(o_in_ready), 32'd1);
    n = idle(1'b1);
    n.rst = 1'b1;
    cycle();
    n = idle(1'b1);
    repeat (3) begin
      cycle();
      chk("post_rst_valid", 32'(o_out_valid), 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      n = '0;
      n.in_valid  = ($urandom_range(0, 3) != 0);
      n.pc        = $urandom;
      n.rs1d      = $urandom;
      n.rs2d      = $urandom;
      n.imm       = $urandom;
      n.rs1a      = 5'($urandom_range(0, 3));
      n.rs2a      = 5'($urandom_range(0, 3));
      n.rda       = 5'($urandom_range(0, 31));
      n.op        = 5'($urandom_range(0, 31));
      n.use_imm   = 1'($urandom_range(0, 1));
      n.use_pc    = 1'($urandom_range(0, 1));
      n.we        = 1'($urandom_range(0, 1));
      n.flush     = ($urandom_range(0, 15) == 0);
      n.out_ready = n.flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      n.ex_we     = 1'($urandom_range(0, 1));
      n.wb_we     = 1'($urandom_range(0, 1));
      n.ex_rd     = 5'($urandom_range(0, 3));
      n.wb_rd     = 5'($urandom_range(0, 3));
      n.ex_res    = $urandom;
      n.wb_res    = $urandom;
      cycle();
    end
    n = idle(1'b1);
    repeat (MDIV + 3) cycle();
    chk("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: MDIV_CYCLES, default 3, occupancy cycles (>=2) for M-extension ops before results are presented.
REQ-002 CLK  in  1  sole clock, all state updates on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 IN_VALID  in  1 / IN_READY  out  1  decode-side handshake.
REQ-005 IN_PC, IN_RS1_DATA, IN_RS2_DATA, IN_IMM  in  32 each  decoded instruction fields.
REQ-006 IN_RS1_ADDR, IN_RS2_ADDR, IN_RD_ADDR  in  5 each  register addresses.
REQ-007 IN_ALU_OP  in  5  ALU opcode. IN_USE_IMM, IN_USE_PC, IN_REG_WRITE  in  1 each  operand selects, writeback enable.
REQ-008 FLUSH  in  1  discard held and offered instruction.
REQ-009 EXMEM_RD_ADDR, MEMWB_RD_ADDR  in  5. EXMEM_REG_WRITE, MEMWB_REG_WRITE  in  1. EXMEM_RESULT, MEMWB_RESULT  in  32  forwarding sources.
REQ-010 OUT_READY  in  1 / OUT_VALID  out  1  execute-side handshake.
REQ-011 DATA1, DATA2  out  32. OPCODE  out  5  direct ALU operand/opcode drive.
REQ-012 OUT_PC  out  32, OUT_RS2_DATA  out  32 (forwarded, store data), OUT_RD_ADDR  out  5, OUT_REG_WRITE  out  1.

Function
REQ-013 One-entry stage; states EMPTY, WAIT (M-op occupancy), FULL.
REQ-014 IN_READY = FLUSH | (state==EMPTY) | (state==FULL & OUT_READY), combinational.
REQ-015 Capture when IN_VALID & IN_READY & !FLUSH; otherwise fields hold.
REQ-016 On capture, IN_ALU_OP[4]==1 (M-ext) -> WAIT, counter loaded 1; else -> FULL.
REQ-017 WAIT: counter increments each cycle; at counter==MDIV_CYCLES-1 -> FULL next edge, so OUT_VALID first rises MDIV_CYCLES cycles after capture.
REQ-018 OUT_VALID = (state==FULL); non-M op: OUT_VALID high the cycle after capture.
REQ-019 FULL & OUT_READY & no capture -> EMPTY; FULL & OUT_READY & capture -> back-to-back load, per REQ-016.
REQ-020 FULL & !OUT_READY: all outputs stable except forwarded operand updates (REQ-023).
REQ-021 FLUSH (any state) -> EMPTY next edge, OUT_REG_WRITE cleared, OPCODE 0; offered instruction dropped; FLUSH beats capture and completion.
REQ-022 Forwarding, per source operand: EXMEM match (REG_WRITE & RD_ADDR==rs & rs!=0) first, then MEMWB match, else stored value; x0 never forwarded.
REQ-023 Stored RS1/RS2 values rewritten each edge while WAIT/FULL with forwarded value, so a producer passing writeback during a stall is not lost.
REQ-024 DATA1 = IN_USE_PC ? stored PC : forwarded RS1; DATA2 = IN_USE_IMM ? stored IMM : forwarded RS2 (selects registered at capture).
REQ-025 DATA1/DATA2/OPCODE are driven in WAIT and FULL; in EMPTY OPCODE=0, DATA1=DATA2=0.
REQ-026 Arithmetic: none in this block; widths pass unmodified, no sign extension performed.

Reset
REQ-027 RESET high: state EMPTY, counter 0, all stored fields 0, OUT_VALID 0, OUT_REG_WRITE 0, OPCODE 0, DATA1/DATA2/OUT_* 0, IN_READY 1.
REQ-028 RESET mid-WAIT or mid-FULL abandons the instruction; no OUT_VALID pulse after release until a new capture.
REQ-029 First capture permitted on the first rising edge after RESET deasserts.

Verification
REQ-030 ADD op 5'b00000, RS1=5, RS2=7, OUT_READY=1 -> OUT_VALID next cycle, DATA1=5, DATA2=7, OPCODE=0, IN_READY stays 1 for back-to-back.
REQ-031 M op (IN_ALU_OP=5'b10000), MDIV_CYCLES=3 -> OUT_VALID low 2 cycles, high on cycle 3; IN_READY low in WAIT.
REQ-032 RS1_ADDR=3, EXMEM rd=3 result 0x11, MEMWB rd=3 result 0x22 -> DATA1=0x11; rs=0 with matching rd 0 -> DATA1=stored value.
REQ-033 FULL, OUT_READY=0 for 4 cycles, MEMWB writes rd=RS2_ADDR value 0xAB in cycle 2 only -> DATA2=0xAB from cycle 2 onward through release.
REQ-034 FLUSH asserted in WAIT with IN_VALID=1 -> EMPTY next cycle, OUT_VALID never rises, offered instruction not captured.
REQ-035 RESET asserted asynchronously mid-FULL -> OUT_VALID and OUT_REG_WRITE 0 immediately, IN_READY 1.
